// File: rtl/ncl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ncl_pkg
//  Description : Shared types and constants for the NCL dual-rail channel sink.
//                Provides the sink FSM state enum, the ki encodings
//                (RFD / RFN), a dual-rail bit type and per-bit classifiers.
//  Revision    : 1.0  initial release
// ============================================================================
package ncl_pkg;

  // Sink FSM states.
  typedef enum logic [1:0] {
    WAIT_NULL = 2'd0,  // word captured, waiting for the NULL wavefront
    HOLD      = 2'd1,  // NULL seen, output buffer still occupied
    WAIT_DATA = 2'd2   // requesting data, buffer free
  } ncl_state_e;

  // ncl_ki encodings seen by the last NCL stage.
  localparam logic RFD = 1'b1;  // request-for-data
  localparam logic RFN = 1'b0;  // request-for-null

  // One dual-rail bit.
  typedef struct packed {
    logic t;
    logic f;
  } dr_bit_t;

  // Exactly one rail high: a valid DATA value.
  function automatic logic dr_is_data(input dr_bit_t b);
    return b.t ^ b.f;
  endfunction

  // Both rails high: never legal in a 4-phase dual-rail channel.
  function automatic logic dr_is_illegal(input dr_bit_t b);
    return b.t & b.f;
  endfunction

  // Both rails low: the NULL spacer.
  function automatic logic dr_is_null(input dr_bit_t b);
    return ~(b.t | b.f);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ncl_dr_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ncl_dr_sync
//  Description : Brings both rails of a W-bit dual-rail word into the clock
//                domain through SYNC flops each, keeps the previous
//                synchronized sample, and classifies the synchronized word.
//  Ports       : clk_25mhz  - clock
//                reset_n    - synchronous active-low reset
//                ncl_t/f    - raw true/false rails (asynchronous)
//                s_t        - synchronized true rails
//                complete   - every bit DATA, none ILLEGAL
//                is_null    - every rail low
//                illegal    - at least one bit with both rails high
//                stable     - synchronized word equals the previous sample
//  Revision    : 1.0  initial release
// ============================================================================
module ncl_dr_sync
  import ncl_pkg::*;
#(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk_25mhz,
  input  logic         reset_n,
  input  logic [W-1:0] ncl_t,
  input  logic [W-1:0] ncl_f,
  output logic [W-1:0] s_t,
  output logic         complete,
  output logic         is_null,
  output logic         illegal,
  output logic         stable
);

  // Stage 0 is the first flop after the asynchronous input; stage SYNC-1
  // is the synchronized value.
  logic [SYNC-1:0][W-1:0] sync_t_q, sync_t_d;
  logic [SYNC-1:0][W-1:0] sync_f_q, sync_f_d;
  logic [W-1:0]           prev_t_q, prev_t_d;
  logic [W-1:0]           prev_f_q, prev_f_d;
  logic [W-1:0]           s_f;

  logic [W-1:0]           bit_data;
  logic [W-1:0]           bit_null;
  logic [W-1:0]           bit_ill;

  always_comb begin
    sync_t_d = {sync_t_q[SYNC-2:0], ncl_t};
    sync_f_d = {sync_f_q[SYNC-2:0], ncl_f};
    prev_t_d = s_t;
    prev_f_d = s_f;
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      sync_t_q <= '0;
      sync_f_q <= '0;
      prev_t_q <= '0;
      prev_f_q <= '0;
    end else begin
      sync_t_q <= sync_t_d;
      sync_f_q <= sync_f_d;
      prev_t_q <= prev_t_d;
      prev_f_q <= prev_f_d;
    end
  end

  assign s_t = sync_t_q[SYNC-1];
  assign s_f = sync_f_q[SYNC-1];

  for (genvar i = 0; i < W; i++) begin : g_bit
    dr_bit_t rail;
    assign rail        = {s_t[i], s_f[i]};
    assign bit_data[i] = dr_is_data(rail);
    assign bit_null[i] = dr_is_null(rail);
    assign bit_ill[i]  = dr_is_illegal(rail);
  end

  // An ILLEGAL bit is neither DATA nor NULL, so it already blocks both
  // complete and is_null; the explicit term keeps that intent visible.
  assign illegal  = |bit_ill;
  assign complete = (&bit_data) & ~illegal;
  assign is_null  = (&bit_null) & ~illegal;

  // A word is acted on only once two consecutive synchronized samples agree,
  // which filters rails that were caught mid-transition.
  assign stable = (s_t == prev_t_q) && (s_f == prev_f_q);

endmodule
`default_nettype wire

// File: rtl/ncl_sync_sink.sv
`default_nettype none
// ============================================================================
//  Module      : ncl_sync_sink
//  Description : Receiving end of a 4-phase dual-rail NCL channel. Converts
//                DATA/NULL wavefronts into a one-entry valid/ready stream and
//                drives the channel acknowledge ncl_ki.
//  Ports       : clk_25mhz  - clock
//                reset_n    - synchronous active-low reset
//                ncl_t/f    - raw true/false rails (asynchronous)
//                ncl_ki     - 1 = request-for-data, 0 = request-for-null
//                out_data   - captured word (true rails)
//                out_valid  - out_data holds an unconsumed word
//                out_ready  - consumer accepts when out_valid & out_ready
//                err        - sticky, a bit was seen with both rails high
//                tok_cnt    - DATA tokens captured, wraps at 2^16
//  Revision    : 1.0  initial release
// ============================================================================
module ncl_sync_sink
  import ncl_pkg::*;
#(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk_25mhz,
  input  logic         reset_n,
  input  logic [W-1:0] ncl_t,
  input  logic [W-1:0] ncl_f,
  output logic         ncl_ki,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err,
  output logic [15:0]  tok_cnt
);

  logic [W-1:0] s_t;
  logic         complete;
  logic         is_null;
  logic         illegal;
  logic         stable;

  ncl_state_e   state_q, state_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         err_q, err_d;
  logic [15:0]  tok_cnt_q, tok_cnt_d;

  ncl_dr_sync #(
    .W    (W),
    .SYNC (SYNC)
  ) u_sync (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .ncl_t     (ncl_t),
    .ncl_f     (ncl_f),
    .s_t       (s_t),
    .complete  (complete),
    .is_null   (is_null),
    .illegal   (illegal),
    .stable    (stable)
  );

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q | illegal;
    tok_cnt_d   = tok_cnt_q;

    // Consumer pop; resolved first so HOLD can release on the same edge.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      WAIT_NULL: begin
        if (is_null && stable) begin
          state_d = out_valid_q ? HOLD : WAIT_DATA;
        end
      end
      HOLD: begin
        if (!out_valid_d) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // The buffer is always empty here, so capture never overwrites.
        if (complete && stable) begin
          out_data_d  = s_t;
          out_valid_d = 1'b1;
          tok_cnt_d   = tok_cnt_q + 16'd1;
          state_d     = WAIT_NULL;
        end
      end
      default: begin
        state_d = WAIT_NULL;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      state_q     <= WAIT_NULL;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      tok_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      tok_cnt_q   <= tok_cnt_d;
    end
  end

  // Pure decode of the state register, so ki never glitches.
  assign ncl_ki    = (state_q == WAIT_DATA) ? RFD : RFN;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign tok_cnt   = tok_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ncl_sync_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ncl_sync_sink
//  Description : Self-checking bench for ncl_sync_sink. Directed vector table,
//                hand-written corner sequences and randomized rails checked
//                against a cycle-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ncl_sync_sink;

  localparam int W    = 8;
  localparam int SYNC = 2;

  logic         clk_25mhz;
  logic         reset_n;
  logic [W-1:0] ncl_t;
  logic [W-1:0] ncl_f;
  logic         ncl_ki;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         err;
  logic [15:0]  tok_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  ncl_sync_sink #(
    .W    (W),
    .SYNC (SYNC)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .ncl_t     (ncl_t),
    .ncl_f     (ncl_f),
    .ncl_ki    (ncl_ki),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .tok_cnt   (tok_cnt)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  // --------------------------------------------------------------------------
  // Reference model. h_t/h_f[k] is the rail word the DUT sampled k+1 edges
  // ago, so the synchronized word seen before an edge is entry SYNC-1 and the
  // sample before that is entry SYNC.
  // --------------------------------------------------------------------------
  logic [W-1:0] h_t [0:SYNC];
  logic [W-1:0] h_f [0:SYNC];
  logic         m_ki;        // requesting data
  logic         m_nullseen;  // NULL arrived while the buffer was still full
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_err;
  logic [15:0]  m_cnt;

  task automatic model_edge();
    logic [W-1:0] st, sf;
    int     n_data, n_null, n_ill;
    logic   m_complete, m_isnull, m_stable, pop, old_valid, nv;
    if (!reset_n) begin
      for (int k = 0; k <= SYNC; k++) begin
        h_t[k] = '0;
        h_f[k] = '0;
      end
      m_ki = 0; m_nullseen = 0; m_valid = 0; m_data = '0; m_err = 0; m_cnt = 16'd0;
      return;
    end
    st = h_t[SYNC-1];
    sf = h_f[SYNC-1];
    n_data = 0; n_null = 0; n_ill = 0;
    for (int b = 0; b < W; b++) begin
      if (st[b] && sf[b])        n_ill++;
      else if (st[b] || sf[b])   n_data++;
      else                       n_null++;
    end
    m_complete = (n_data == W);
    m_isnull   = (n_null == W);
    m_stable   = (st == h_t[SYNC]) && (sf == h_f[SYNC]);
    if (n_ill != 0) m_err = 1;
    old_valid = m_valid;
    pop       = m_valid && out_ready;
    nv        = pop ? 1'b0 : m_valid;
    if (m_ki) begin
      if (m_complete && m_stable) begin
        m_data = st;
        nv     = 1;
        m_cnt  = m_cnt + 16'd1;
        m_ki   = 0;
      end
    end else if (m_nullseen) begin
      if (!nv) begin
        m_ki       = 1;
        m_nullseen = 0;
      end
    end else if (m_isnull && m_stable) begin
      if (!old_valid) m_ki = 1;
      else            m_nullseen = 1;
    end
    m_valid = nv;
    for (int k = SYNC; k > 0; k--) begin
      h_t[k] = h_t[k-1];
      h_f[k] = h_f[k-1];
    end
    h_t[0] = ncl_t;
    h_f[0] = ncl_f;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT sees at that
  // edge, then compare just after it.
  task automatic tick();
    model_edge();
    @(posedge clk_25mhz);
    #1;
    chk("model_ki",    32'(ncl_ki),    32'(m_ki));
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    chk("model_err",   32'(err),       32'(m_err));
    chk("model_cnt",   32'(tok_cnt),   32'(m_cnt));
    if (m_valid) chk("model_data", 32'(out_data), 32'(m_data));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] t;
    logic [W-1:0] f;
    logic         rdy;
    int           n;
    logic         ki;
    logic         valid;
    logic [W-1:0] data;
    logic [15:0]  cnt;
  } vec_t;

  vec_t vt [16];

  initial begin
    // token A5: capture on the 4th edge, pop, NULL return
    vt[0]  = '{8'hA5, 8'h5A, 1'b0,  3, 1'b1, 1'b0, 8'h00, 16'd0};
    vt[1]  = '{8'hA5, 8'h5A, 1'b0,  1, 1'b0, 1'b1, 8'hA5, 16'd1};
    vt[2]  = '{8'hA5, 8'h5A, 1'b1,  1, 1'b0, 1'b0, 8'hA5, 16'd1};
    vt[3]  = '{8'h00, 8'h00, 1'b0,  3, 1'b0, 1'b0, 8'hA5, 16'd1};
    vt[4]  = '{8'h00, 8'h00, 1'b0,  1, 1'b1, 1'b0, 8'hA5, 16'd1};
    // token 01 held by a stalled consumer, NULL parks in HOLD
    vt[5]  = '{8'h01, 8'hFE, 1'b0,  4, 1'b0, 1'b1, 8'h01, 16'd2};
    vt[6]  = '{8'h00, 8'h00, 1'b0, 50, 1'b0, 1'b1, 8'h01, 16'd2};
    vt[7]  = '{8'h00, 8'h00, 1'b1,  1, 1'b1, 1'b0, 8'h01, 16'd2};
    // partial DATA (bit 7 NULL) waits, completing bit 7 captures 7F
    vt[8]  = '{8'h7F, 8'h00, 1'b0, 20, 1'b1, 1'b0, 8'h01, 16'd2};
    vt[9]  = '{8'h7F, 8'h80, 1'b0,  3, 1'b1, 1'b0, 8'h01, 16'd2};
    vt[10] = '{8'h7F, 8'h80, 1'b0,  1, 1'b0, 1'b1, 8'h7F, 16'd3};
    vt[11] = '{8'h7F, 8'h80, 1'b1,  1, 1'b0, 1'b0, 8'h7F, 16'd3};
    vt[12] = '{8'h00, 8'h00, 1'b0,  4, 1'b1, 1'b0, 8'h7F, 16'd3};
    // partial NULL return waits without error
    vt[13] = '{8'h3C, 8'hC3, 1'b0,  4, 1'b0, 1'b1, 8'h3C, 16'd4};
    vt[14] = '{8'h0C, 8'hC0, 1'b1, 10, 1'b0, 1'b0, 8'h3C, 16'd4};
    vt[15] = '{8'h00, 8'h00, 1'b0,  4, 1'b1, 1'b0, 8'h3C, 16'd4};
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset_n   = 1'b0;
    ncl_t     = '0;
    ncl_f     = '0;
    out_ready = 1'b0;

    // Reset with rails at NULL
    ticks(2);
    chk("reset_ki",    32'(ncl_ki),    32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data",  32'(out_data),  32'd0);
    chk("reset_err",   32'(err),       32'd0);
    chk("reset_cnt",   32'(tok_cnt),   32'd0);
    reset_n = 1'b1;
    ticks(4);
    chk("rfd_after_reset", 32'(ncl_ki), 32'd1);

    // Directed table
    for (int v = 0; v < 16; v++) begin
      ncl_t     = vt[v].t;
      ncl_f     = vt[v].f;
      out_ready = vt[v].rdy;
      ticks(vt[v].n);
      chk($sformatf("vec%0d_ki", v),    32'(ncl_ki),    32'(vt[v].ki));
      chk($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vt[v].valid));
      chk($sformatf("vec%0d_data", v),  32'(out_data),  32'(vt[v].data));
      chk($sformatf("vec%0d_cnt", v),   32'(tok_cnt),   32'(vt[v].cnt));
      chk($sformatf("vec%0d_err", v),   32'(err),       32'd0);
    end

    // ILLEGAL bit 3: err after SYNC+1 edges, no capture, sticky until reset
    out_ready = 1'b0;
    ncl_t = 8'h0F;
    ncl_f = 8'hF8;
    ticks(SYNC);
    chk("illegal_err_early", 32'(err), 32'd0);
    tick();
    chk("illegal_err_set", 32'(err), 32'd1);
    ticks(7);
    chk("illegal_no_capture", 32'(out_valid), 32'd0);
    chk("illegal_cnt", 32'(tok_cnt), 32'd4);
    ncl_t = '0;
    ncl_f = '0;
    ticks(6);
    chk("illegal_err_sticky", 32'(err), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("illegal_err_cleared", 32'(err), 32'd0);
    reset_n = 1'b1;
    ticks(2);

    // Reset mid-token discards it
    ncl_t = 8'h96;
    ncl_f = 8'h69;
    ticks(3);
    reset_n = 1'b0;
    tick();
    ncl_t   = '0;
    ncl_f   = '0;
    reset_n = 1'b1;
    ticks(6);
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_cnt",   32'(tok_cnt),   32'd0);
    chk("midreset_ki",    32'(ncl_ki),    32'd1);

    // Counter wrap
    force dut.tok_cnt_q = 16'hFFFF;
    #2;
    release dut.tok_cnt_q;
    m_cnt = 16'hFFFF;
    ncl_t = 8'hC3;
    ncl_f = 8'h3C;
    ticks(4);
    chk("wrap_cnt",   32'(tok_cnt),   32'd0);
    chk("wrap_valid", 32'(out_valid), 32'd1);
    chk("wrap_data",  32'(out_data),  32'hC3);
    out_ready = 1'b1;
    tick();
    ncl_t = '0;
    ncl_f = '0;
    ticks(4);

    // Randomized rails and consumer against the model
    for (int it = 0; it < 600; it++) begin
      int kind;
      int hold;
      logic [W-1:0] r, mask;
      kind = $urandom_range(0, 19);
      hold = $urandom_range(1, 6);
      r    = W'($urandom);
      mask = W'($urandom);
      if (kind < 7) begin
        ncl_t = r;                       // full DATA word
        ncl_f = ~r;
      end else if (kind < 13) begin
        ncl_t = '0;                      // NULL
        ncl_f = '0;
      end else if (kind < 16) begin
        ncl_t = r & mask;                // partial DATA / partial NULL
        ncl_f = ~r & mask;
      end else if (kind < 18) begin
        ncl_t = ncl_t ^ (W'(1) << $urandom_range(0, W-1));  // single rail flip
        hold  = 1;
      end else if (kind == 18 && it > 450) begin
        ncl_t = r;                       // arbitrary rails, may be ILLEGAL
        ncl_f = mask;
      end else begin
        reset_n = 1'b0;
      end
      for (int h = 0; h < hold; h++) begin
        out_ready = 1'($urandom_range(0, 2) != 0);
        tick();
        reset_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
